// File: rtl/interrupt_sequencer.sv
// Prioritized, nesting interrupt sequencer: latches edge requests, arbitrates against the
// in-service level at sequential instruction boundaries, and drives the PC select for entry/ERET.
module interrupt_sequencer #(
    parameter int          NUM_SRC    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [NUM_SRC-1:0] in_irq,
    input  logic [NUM_SRC-1:0] in_clr,
    input  logic               in_inst_valid,
    input  logic               in_cidi_control,
    input  logic               in_eret,
    input  logic [31:0]        in_pc,
    output logic [1:0]         out_pc_sel,
    output logic [31:0]        out_vector,
    output logic [31:0]        out_epc,
    output logic               out_stall,
    output logic [NUM_SRC-1:0] out_pending,
    output logic [NUM_SRC-1:0] out_in_service
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SPW  = $clog2(NUM_SRC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        VECTOR,
        RETURN
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SRC-1:0]  irq_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  inService_q, inService_d;
    logic [IDXW-1:0]     capIdx_q, capIdx_d;
    logic [31:0]         capPc_q, capPc_d;
    logic [31:0]         vector_q, vector_d;
    logic [31:0]         epc_q, epc_d;
    logic [SPW-1:0]      sp_q, sp_d;
    logic [31:0]         stack_q [NUM_SRC];

    logic [NUM_SRC-1:0]  newReq;
    logic                candValid;
    logic [IDXW-1:0]     candIdx;
    logic                svcValid;
    logic [IDXW-1:0]     svcIdx;
    logic                accept;
    logic                push;
    logic                pop;
    logic [1:0]          pcSel;
    logic                stall;
    logic [SPW-1:0]      belowIdx;

    assign newReq = in_irq & ~irq_q;

    // Highest-index set bit wins for both the pending candidate and the service level.
    always_comb begin
        candValid = 1'b0;
        candIdx   = '0;
        svcValid  = 1'b0;
        svcIdx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_q[i]) begin
                candValid = 1'b1;
                candIdx   = IDXW'(i);
            end
            if (inService_q[i]) begin
                svcValid = 1'b1;
                svcIdx   = IDXW'(i);
            end
        end
    end

    assign accept = candValid && (!svcValid || (candIdx > svcIdx));

    always_comb begin
        state_d  = state_q;
        capIdx_d = capIdx_q;
        capPc_d  = capPc_q;
        vector_d = vector_q;
        pcSel    = 2'b00;
        stall    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ERET outranks acceptance; a branch-taking instruction is never split.
                if (in_inst_valid && in_eret) begin
                    if (sp_q != '0) begin
                        state_d = RETURN;
                    end
                end else if (in_inst_valid && in_cidi_control && accept) begin
                    state_d  = SAVE;
                    capIdx_d = candIdx;
                    capPc_d  = in_pc;
                    vector_d = VEC_BASE + (32'(candIdx) * VEC_STRIDE);
                end
            end
            SAVE: begin
                stall   = 1'b1;
                push    = 1'b1;
                state_d = VECTOR;
            end
            VECTOR: begin
                pcSel   = 2'b01;
                state_d = IDLE;
            end
            RETURN: begin
                pcSel   = 2'b10;
                pop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign belowIdx = sp_q - SPW'(2);

    // A new edge beats both software clear and the SAVE-time clear of the same bit.
    always_comb begin
        pending_d   = pending_q & ~in_clr;
        inService_d = inService_q;
        sp_d        = sp_q;
        epc_d       = epc_q;
        if (push) begin
            pending_d[capIdx_q]   = 1'b0;
            inService_d[capIdx_q] = 1'b1;
            sp_d                  = sp_q + SPW'(1);
            epc_d                 = capPc_q;
        end
        if (pop) begin
            if (svcValid) begin
                inService_d[svcIdx] = 1'b0;
            end
            sp_d  = sp_q - SPW'(1);
            epc_d = (sp_q >= SPW'(2)) ? stack_q[belowIdx] : 32'h0;
        end
        pending_d = pending_d | newReq;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= IDLE;
            irq_q       <= '0;
            pending_q   <= '0;
            inService_q <= '0;
            capIdx_q    <= '0;
            capPc_q     <= '0;
            vector_q    <= '0;
            epc_q       <= '0;
            sp_q        <= '0;
        end else begin
            state_q     <= state_d;
            irq_q       <= in_irq;
            pending_q   <= pending_d;
            inService_q <= inService_d;
            capIdx_q    <= capIdx_d;
            capPc_q     <= capPc_d;
            vector_q    <= vector_d;
            epc_q       <= epc_d;
            sp_q        <= sp_d;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[sp_q] <= capPc_q;
        end
    end

    assign out_pc_sel     = pcSel;
    assign out_stall      = stall;
    assign out_vector     = vector_q;
    assign out_epc        = epc_q;
    assign out_pending    = pending_q;
    assign out_in_service = inService_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed cycle-by-cycle vectors for interrupt_sequencer: entry, nesting, masking,
// branch deferral, clear/set races, ERET with an empty stack and reset during SAVE.
module tb_interrupt_sequencer;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [2:0]  in_irq;
    logic [2:0]  in_clr;
    logic        in_inst_valid;
    logic        in_cidi_control;
    logic        in_eret;
    logic [31:0] in_pc;
    logic [1:0]  out_pc_sel;
    logic [31:0] out_vector;
    logic [31:0] out_epc;
    logic        out_stall;
    logic [2:0]  out_pending;
    logic [2:0]  out_in_service;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  irq;
        logic [2:0]  clr;
        logic        valid;
        logic        cidi;
        logic        eret;
        logic [31:0] pc;
        logic [1:0]  expSel;
        logic        expStall;
        logic [31:0] expVec;
        logic [31:0] expEpc;
        logic [2:0]  expPend;
        logic [2:0]  expSvc;
    } vec_t;

    vec_t vecs[$];

    interrupt_sequencer #(
        .NUM_SRC    (3),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_irq          (in_irq),
        .in_clr          (in_clr),
        .in_inst_valid   (in_inst_valid),
        .in_cidi_control (in_cidi_control),
        .in_eret         (in_eret),
        .in_pc           (in_pc),
        .out_pc_sel      (out_pc_sel),
        .out_vector      (out_vector),
        .out_epc         (out_epc),
        .out_stall       (out_stall),
        .out_pending     (out_pending),
        .out_in_service  (out_in_service)
    );

    always #5 in_clk = ~in_clk;

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [2:0] irq, input logic [2:0] clr,
                                 input logic valid, input logic cidi, input logic eret,
                                 input logic [31:0] pc);
        in_rst          = rst;
        in_irq          = irq;
        in_clr          = clr;
        in_inst_valid   = valid;
        in_cidi_control = cidi;
        in_eret         = eret;
        in_pc           = pc;
        @(posedge in_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] sel, input logic stall,
                            input logic [31:0] vec, input logic [31:0] epc,
                            input logic [2:0] pend, input logic [2:0] svc);
        checkOutput({tag, " pc_sel"},     32'(out_pc_sel),     32'(sel));
        checkOutput({tag, " stall"},      32'(out_stall),      32'(stall));
        checkOutput({tag, " vector"},     out_vector,          vec);
        checkOutput({tag, " epc"},        out_epc,             epc);
        checkOutput({tag, " pending"},    32'(out_pending),    32'(pend));
        checkOutput({tag, " in_service"}, 32'(out_in_service), 32'(svc));
    endtask

    task automatic addRow(input logic [2:0] irq, input logic [2:0] clr, input logic valid,
                          input logic cidi, input logic eret, input logic [31:0] pc,
                          input logic [1:0] sel, input logic stall, input logic [31:0] vec,
                          input logic [31:0] epc, input logic [2:0] pend, input logic [2:0] svc);
        vec_t v;
        v.irq = irq; v.clr = clr; v.valid = valid; v.cidi = cidi; v.eret = eret; v.pc = pc;
        v.expSel = sel; v.expStall = stall; v.expVec = vec; v.expEpc = epc;
        v.expPend = pend; v.expSvc = svc;
        vecs.push_back(v);
    endtask

    initial begin
        // Basic entry of source 0 from pc 0x40
        addRow(3'b001, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h000, 32'h000, 3'b001, 3'b000); // r0
        addRow(3'b000, 3'b000, 1, 1, 0, 32'h40,  2'b00, 1, 32'h100, 32'h000, 3'b001, 3'b000); // r1 SAVE
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b01, 0, 32'h100, 32'h040, 3'b000, 3'b001); // r2 VECTOR
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h100, 32'h040, 3'b000, 3'b001); // r3
        // Nesting: source 2 over source 0, level held afterwards
        addRow(3'b100, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h100, 32'h040, 3'b100, 3'b001); // r4
        addRow(3'b100, 3'b000, 1, 1, 0, 32'h108, 2'b00, 1, 32'h120, 32'h040, 3'b100, 3'b001); // r5 SAVE
        addRow(3'b100, 3'b000, 0, 0, 0, 32'h0,   2'b01, 0, 32'h120, 32'h108, 3'b000, 3'b101); // r6 VECTOR
        addRow(3'b100, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h108, 3'b000, 3'b101); // r7
        addRow(3'b000, 3'b000, 1, 1, 1, 32'h0,   2'b10, 0, 32'h120, 32'h108, 3'b000, 3'b101); // r8 RETURN
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h040, 3'b000, 3'b001); // r9
        addRow(3'b000, 3'b000, 1, 1, 1, 32'h0,   2'b10, 0, 32'h120, 32'h040, 3'b000, 3'b001); // r10 RETURN
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h000, 3'b000, 3'b000); // r11
        // ERET with an empty stack is ignored
        addRow(3'b000, 3'b000, 1, 1, 1, 32'h0,   2'b00, 0, 32'h120, 32'h000, 3'b000, 3'b000); // r12
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h000, 3'b000, 3'b000); // r13
        // Masking: source 1 waits behind source 2
        addRow(3'b100, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h000, 3'b100, 3'b000); // r14
        addRow(3'b000, 3'b000, 1, 1, 0, 32'h200, 2'b00, 1, 32'h120, 32'h000, 3'b100, 3'b000); // r15 SAVE
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b01, 0, 32'h120, 32'h200, 3'b000, 3'b100); // r16 VECTOR
        addRow(3'b010, 3'b000, 1, 1, 0, 32'h300, 2'b00, 0, 32'h120, 32'h200, 3'b010, 3'b100); // r17
        addRow(3'b010, 3'b000, 1, 1, 0, 32'h304, 2'b00, 0, 32'h120, 32'h200, 3'b010, 3'b100); // r18 masked
        addRow(3'b000, 3'b000, 1, 1, 1, 32'h0,   2'b10, 0, 32'h120, 32'h200, 3'b010, 3'b100); // r19 RETURN
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h000, 3'b010, 3'b000); // r20
        addRow(3'b000, 3'b000, 1, 1, 0, 32'h400, 2'b00, 1, 32'h110, 32'h000, 3'b010, 3'b000); // r21 SAVE
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b01, 0, 32'h110, 32'h400, 3'b000, 3'b010); // r22 VECTOR
        // Branch deferral: taken branches do not accept
        addRow(3'b100, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h110, 32'h400, 3'b100, 3'b010); // r23
        addRow(3'b000, 3'b000, 1, 0, 0, 32'h500, 2'b00, 0, 32'h110, 32'h400, 3'b100, 3'b010); // r24
        addRow(3'b000, 3'b000, 1, 0, 0, 32'h500, 2'b00, 0, 32'h110, 32'h400, 3'b100, 3'b010); // r25
        addRow(3'b000, 3'b000, 1, 1, 0, 32'h504, 2'b00, 1, 32'h120, 32'h400, 3'b100, 3'b010); // r26 SAVE
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b01, 0, 32'h120, 32'h504, 3'b000, 3'b110); // r27 VECTOR
        // Set beats clear; a held line then clears normally
        addRow(3'b001, 3'b001, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h504, 3'b001, 3'b110); // r28
        addRow(3'b001, 3'b001, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h504, 3'b000, 3'b110); // r29
        // Unwind both levels
        addRow(3'b000, 3'b000, 1, 1, 1, 32'h0,   2'b10, 0, 32'h120, 32'h504, 3'b000, 3'b110); // r30 RETURN
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h400, 3'b000, 3'b010); // r31
        addRow(3'b000, 3'b000, 1, 1, 1, 32'h0,   2'b10, 0, 32'h120, 32'h400, 3'b000, 3'b010); // r32 RETURN
        addRow(3'b000, 3'b000, 0, 0, 0, 32'h0,   2'b00, 0, 32'h120, 32'h000, 3'b000, 3'b000); // r33

        applyStimulus(1, 3'b000, 3'b000, 0, 0, 0, 32'h0);
        applyStimulus(1, 3'b000, 3'b000, 0, 0, 0, 32'h0);
        checkAll("reset", 2'b00, 0, 32'h0, 32'h0, 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].irq, vecs[i].clr, vecs[i].valid, vecs[i].cidi,
                          vecs[i].eret, vecs[i].pc);
            checkAll($sformatf("row%0d", i), vecs[i].expSel, vecs[i].expStall, vecs[i].expVec,
                     vecs[i].expEpc, vecs[i].expPend, vecs[i].expSvc);
        end

        // Reset asserted while in SAVE must abort the entry without a push
        applyStimulus(0, 3'b001, 3'b000, 0, 0, 0, 32'h0);
        applyStimulus(0, 3'b000, 3'b000, 1, 1, 0, 32'h80);
        checkOutput("midsave stall", 32'(out_stall), 32'd1);
        applyStimulus(1, 3'b000, 3'b000, 0, 0, 0, 32'h0);
        checkAll("midsave reset", 2'b00, 0, 32'h0, 32'h0, 3'b000, 3'b000);
        applyStimulus(0, 3'b000, 3'b000, 0, 0, 0, 32'h0);
        checkAll("midsave after", 2'b00, 0, 32'h0, 32'h0, 3'b000, 3'b000);
        applyStimulus(0, 3'b000, 3'b000, 1, 1, 1, 32'h0);
        checkAll("midsave eret", 2'b00, 0, 32'h0, 32'h0, 3'b000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Prioritized, nesting interrupt controller that owns the PC next-address select alongside the branch condition logic. It latches edge-triggered requests and arbitrates them against the in-service level. It takes an interrupt only at a sequential instruction boundary, so a taken branch is never split. It then sequences the EPC save and the vector redirect, and services ERET by popping the EPC stack.

## Interface
- NUM_SRC, 3, number of interrupt sources; index NUM_SRC-1 is highest priority
- VEC_BASE, 32'h0000_0100, vector address of source 0
- VEC_STRIDE, 32'h0000_0010, vector spacing per source index

Ports:
- in_clk  input  1  system clock; all state updates on rising edge
- in_rst  input  1  synchronous, active-high reset
- in_irq  input  NUM_SRC  raw request lines, rising-edge sensitive
- in_clr  input  NUM_SRC  software clear of pending bits
- in_inst_valid  input  1  an instruction completes this cycle
- in_cidi_control  input  1  branch-condition result; 1 = sequential PC (no branch taken)
- in_eret  input  1  completing instruction is ERET (qualified by in_inst_valid)
- in_pc  input  32  address of the next sequential instruction (return address)
- out_pc_sel  output  2  00 normal, 01 vector, 10 EPC
- out_vector  output  32  vector target, valid when out_pc_sel=01
- out_epc  output  32  top of the EPC stack
- out_stall  output  1  freezes PC and issue
- out_pending  output  NUM_SRC  pending request bits
- out_in_service  output  NUM_SRC  sources currently being serviced

## Operation
- Edge detect: in_irq is registered into irq_q. A bit is newly requested when in_irq & ~irq_q. A new request sets the pending bit, and in_clr clears it. Set wins when both occur in the same cycle.
- Service level: the index of the highest set out_in_service bit, or -1 if none. The candidate is the highest-index pending bit.
- Accept condition: state IDLE, in_inst_valid=1, in_cidi_control=1, in_eret=0, and candidate index > service level. ERET has priority over acceptance.
- EPC stack: depth NUM_SRC, 32-bit entries, with stack pointer sp in 0..NUM_SRC. Acceptance cannot overflow the stack, because each source can be in service only once.
- FSM states: IDLE, SAVE, VECTOR, RETURN.
  - IDLE -> SAVE on accept. The chosen index and in_pc are captured.
  - SAVE (1 cycle): out_stall=1. Push the captured PC, increment sp, clear the pending bit, set the in_service bit. Next state is VECTOR.
  - VECTOR (1 cycle): out_pc_sel=01, out_vector = VEC_BASE + idx*VEC_STRIDE, computed modulo 2^32. Next state is IDLE.
  - IDLE -> RETURN when in_inst_valid & in_eret and sp>0.
  - RETURN (1 cycle): out_pc_sel=10, out_epc = top entry. Pop the entry, decrement sp, clear the highest in_service bit. Next state is IDLE.
- ERET with sp=0 is ignored: no state change and out_pc_sel stays 00.
- While not in IDLE, requests still latch into pending, but nothing is accepted.
- Reset values: state=IDLE, pending=0, in_service=0, sp=0, irq_q=0, out_pc_sel=00, out_stall=0, out_vector=0, out_epc=0. Reset in any state aborts the sequence, and no partial push remains.

## Timing
- Request latency: in_irq rises before edge T. The pending bit is visible after T.
- Interrupt entry:
  - Accept is sampled at edge A.
  - SAVE occupies cycle A+1 (out_stall high).
  - VECTOR occupies cycle A+2.
  - The first handler fetch is at A+3.
- Interrupt return: ERET is sampled at edge E. RETURN occupies cycle E+1, and the fetch from EPC is at E+2.
- out_epc is registered: it reflects the top entry in the cycle after a push.
- Back-to-back: a higher-priority request that is pending when VECTOR ends may be accepted at the first qualifying IDLE boundary. There is no dead cycle beyond IDLE itself.
- An instruction with in_cidi_control=0 defers acceptance to the next sequential boundary.

## Test plan
- Basic entry: pulse in_irq[0] with in_pc=32'h0000_0040 and a valid sequential instruction.
  - Required: out_stall=1 for one cycle.
  - Then out_pc_sel=01 with out_vector=32'h0000_0100.
  - out_in_service=3'b001 and out_epc=32'h40.
- Branch deferral: request pending while in_cidi_control=0, followed by a sequential instruction.
  - Required: no accept during the branch.
  - Vector on the first in_cidi_control=1 boundary.
- Nesting: source 0 in service, then in_irq[2] with in_pc=32'h0000_0108.
  - Required: vector 32'h0000_0120, out_in_service=3'b101, sp=2.
  - First ERET returns 32'h108 and clears bit 2. Second ERET returns 32'h40 and clears bit 0.
- Masking by level: source 2 in service, then in_irq[1] raised.
  - Required: pending[1]=1 and no accept.
  - After ERET, source 1 is accepted at the next boundary.
- Edge cases:
  - ERET with sp=0: required out_pc_sel=00 with no state change.
  - in_irq rise coincident with in_clr on the same bit: required pending set.
  - Level held high after service: required no re-trigger.
- Reset mid-SAVE: assert in_rst during SAVE.
  - Required: all outputs at reset values the next cycle.
  - sp=0 and no vector is issued.
